regfile_sb: RTL and testbench

//  Parametrised CPU general-purpose register file: 2 combinational read ports, 1 write port, R0 hardwired to zero.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_sb_if.sv | 37 +++
 rtl/regfile_scoreboard.sv | 37 +++
 rtl/regfile_sb.sv | 144 ++++++++++++++
 tb/tb_regfile_sb.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file.
// Optional same-cycle write bypass is enabled by REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 4;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  // True for a writable register: nonzero and below the register count
  function automatic logic is_gpr(
    input int unsigned addr,
    input int unsigned nregs
  );
    return (addr != 0) && (addr < nregs);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the regfile_sb register file.
// Optional same-cycle write bypass is enabled by REGFILE_BYPASS_EN.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              iClear;
  logic              oBusy;
  logic [ADDR_W-1:0] iAddrA;
  logic [ADDR_W-1:0] iAddrB;
  logic [DATA_W-1:0] oRegA;
  logic [DATA_W-1:0] oRegB;
  logic              oValidA;
  logic              oValidB;
  logic              iWrite;
  logic [ADDR_W-1:0] iAddrC;
  logic [DATA_W-1:0] iRegC;
  logic              iReserve;
  logic [ADDR_W-1:0] iAddrR;
  logic              oResvOk;

  modport master (
    output iClear, iAddrA, iAddrB,
    output iWrite, iAddrC, iRegC,
    output iReserve, iAddrR,
    input  oBusy, oRegA, oRegB,
    input  oValidA, oValidB, oResvOk
  );

  modport slave (
    input  iClear, iAddrA, iAddrB,
    input  iWrite, iAddrC, iRegC,
    input  iReserve, iAddrR,
    output oBusy, oRegA, oRegB,
    output oValidA, oValidB, oResvOk
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write bits: set on reserve, cleared on writeback or sweep.
// Optional same-cycle write bypass is enabled by REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic              i_clr_all,
  output logic [NREGS-1:0]  o_pending
);

  logic [NREGS-1:0] r_pend;

  // Per-bit update; a reserve beats a same-cycle writeback
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_pend <= '0;
    end else if (i_clr_all) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i_set && i_set_addr == ADDR_W'(i))
          r_pend[i] <= 1'b1;
        else if (i_clr && i_clr_addr == ADDR_W'(i))
          r_pend[i] <= 1'b0;
      end
    end
  end

  assign o_pending = r_pend;

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending scoreboard and multi-cycle clear sweep.
// Optional same-cycle write bypass is enabled by REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int NREGS  = (1 << ADDR_W)
) (
  input  logic        iClk,
  input  logic        nRst,
  regfile_sb_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0] r_regs [NREGS];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_sweep_we;
  logic              w_clr_all;
  logic              w_busy;
  logic              w_we;
  logic              w_resv;
  logic              w_a_gpr;
  logic              w_b_gpr;
  logic              w_r_gpr;
  logic [NREGS-1:0]  w_pend;

  assign w_busy  = (r_state == CLEAR);
  assign w_a_gpr = is_gpr(32'(bus.iAddrA), NREGS);
  assign w_b_gpr = is_gpr(32'(bus.iAddrB), NREGS);
  assign w_r_gpr = is_gpr(32'(bus.iAddrR), NREGS);
  assign w_we    = bus.iWrite && !w_busy
                && is_gpr(32'(bus.iAddrC), NREGS);
  assign w_resv  = bus.iReserve && !w_busy
                && w_r_gpr && !w_pend[bus.iAddrR];

  assign bus.oBusy   = w_busy;
  assign bus.oResvOk = w_resv;

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .iClk       (iClk),
    .nRst       (nRst),
    .i_set      (w_resv),
    .i_set_addr (bus.iAddrR),
    .i_clr      (w_we),
    .i_clr_addr (bus.iAddrC),
    .i_clr_all  (w_clr_all),
    .o_pending  (w_pend)
  );

  // Sweep state and counter registers
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sweep next-state: one register zeroed per cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sweep_we  = 1'b0;
    w_clr_all   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.iClear) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        w_sweep_we = 1'b1;
        if (r_cnt == LAST) begin
          w_clr_all   = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Storage: sweep zeroing, else writeback; R0 never written
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (w_sweep_we) begin
      r_regs[r_cnt] <= '0;
    end else if (w_we) begin
      r_regs[bus.iAddrC] <= bus.iRegC;
    end
  end

  // Read port A: zero for R0/out of range, optional bypass
  always_comb begin
    bus.oRegA   = '0;
    bus.oValidA = 1'b1;
    if (w_a_gpr) begin
      bus.oRegA   = r_regs[bus.iAddrA];
      bus.oValidA = !w_pend[bus.iAddrA] && !w_busy;
`ifdef REGFILE_BYPASS_EN
      if (w_we && bus.iAddrA == bus.iAddrC) begin
        bus.oRegA   = bus.iRegC;
        bus.oValidA = 1'b1;
      end
`endif
    end
  end

  // Read port B: zero for R0/out of range, optional bypass
  always_comb begin
    bus.oRegB   = '0;
    bus.oValidB = 1'b1;
    if (w_b_gpr) begin
      bus.oRegB   = r_regs[bus.iAddrB];
      bus.oValidB = !w_pend[bus.iAddrB] && !w_busy;
`ifdef REGFILE_BYPASS_EN
      if (w_we && bus.iAddrB == bus.iAddrC) begin
        bus.oRegB   = bus.iRegC;
        bus.oValidB = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb.
// Expectations adapt to REGFILE_BYPASS_EN.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic nRst;
  int   checks;
  int   errors;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  regfile_sb #(
    .DATA_W (32),
    .ADDR_W (4),
    .NREGS  (16)
  ) dut (
    .iClk (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.iClear   = 1'b0;
    bus.iWrite   = 1'b0;
    bus.iReserve = 1'b0;
    bus.iAddrC   = '0;
    bus.iRegC    = '0;
    bus.iAddrR   = '0;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d);
    bus.iWrite = 1'b1;
    bus.iAddrC = a;
    bus.iRegC  = d;
    tick();
    bus.iWrite = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRst   = 1'b0;
    idle_in();
    bus.iAddrA = 4'd3;
    bus.iAddrB = 4'd0;
    #12;
    check("rst_busy", 32'(bus.oBusy), 32'd0);
    check("rst_r3", bus.oRegA, 32'd0);
    check("rst_va", 32'(bus.oValidA), 32'd1);
    nRst = 1'b1;
    tick();

    // 1: write then read
    wr(4'd3, 32'hDEADBEEF);
    bus.iAddrA = 4'd3;
    bus.iAddrB = 4'd0;
    #1;
    check("t1_rega", bus.oRegA, 32'hDEADBEEF);
    check("t1_regb", bus.oRegB, 32'd0);
    check("t1_va", 32'(bus.oValidA), 32'd1);
    check("t1_vb", 32'(bus.oValidB), 32'd1);

    // 2: reserve, re-reserve, writeback
    bus.iReserve = 1'b1;
    bus.iAddrR   = 4'd5;
    #1;
    check("t2_resv", 32'(bus.oResvOk), 32'd1);
    tick();
    bus.iReserve = 1'b0;
    bus.iAddrA   = 4'd5;
    #1;
    check("t2_pend", 32'(bus.oValidA), 32'd0);
    bus.iReserve = 1'b1;
    #1;
    check("t2_resv2", 32'(bus.oResvOk), 32'd0);
    bus.iAddrR = 4'd0;
    #1;
    check("t2_resv_r0", 32'(bus.oResvOk), 32'd0);
    bus.iReserve = 1'b0;
    bus.iWrite   = 1'b1;
    bus.iAddrC   = 4'd5;
    bus.iRegC    = 32'h12;
    #1;
    check("t2_byp_d", bus.oRegA,
          BYP ? 32'h12 : 32'h0);
    check("t2_byp_v", 32'(bus.oValidA),
          BYP ? 32'd1 : 32'd0);
    tick();
    bus.iWrite = 1'b0;
    #1;
    check("t2_va", 32'(bus.oValidA), 32'd1);
    check("t2_rega", bus.oRegA, 32'h12);

    // 3: same-cycle write and reserve
    bus.iWrite   = 1'b1;
    bus.iAddrC   = 4'd7;
    bus.iRegC    = 32'h55;
    bus.iReserve = 1'b1;
    bus.iAddrR   = 4'd7;
    #1;
    check("t3_resv", 32'(bus.oResvOk), 32'd1);
    tick();
    idle_in();
    bus.iAddrA = 4'd7;
    #1;
    check("t3_rega", bus.oRegA, 32'h55);
    check("t3_va", 32'(bus.oValidA), 32'd0);

    // 6: bypass behaviour
    wr(4'd9, 32'h11);
    bus.iWrite = 1'b1;
    bus.iAddrC = 4'd9;
    bus.iRegC  = 32'hA5;
    bus.iAddrA = 4'd9;
    #1;
    check("t6_rega", bus.oRegA,
          BYP ? 32'hA5 : 32'h11);
    check("t6_va", 32'(bus.oValidA), 32'd1);
    tick();
    bus.iWrite = 1'b0;
    #1;
    check("t6_next", bus.oRegA, 32'hA5);

    // R0 write dropped
    wr(4'd0, 32'hFF);
    bus.iAddrA = 4'd0;
    #1;
    check("r0_wr", bus.oRegA, 32'd0);

    // 4: fill, then sweep with writes/reserves held
    for (int i = 1; i < 16; i++)
      wr(4'(i), 32'h101 * i);
    bus.iAddrA = 4'd15;
    #1;
    check("t4_fill", bus.oRegA, 32'h101 * 15);
    bus.iClear = 1'b1;
    #1;
    check("t4_pre", 32'(bus.oBusy), 32'd0);
    tick();
    bus.iClear   = 1'b0;
    bus.iWrite   = 1'b1;
    bus.iAddrC   = 4'd15;
    bus.iRegC    = 32'hBAD;
    bus.iReserve = 1'b1;
    bus.iAddrR   = 4'd3;
    bus.iAddrA   = 4'd1;
    bus.iAddrB   = 4'd0;
    #1;
    check("t4_busy0", 32'(bus.oBusy), 32'd1);
    check("t4_resv", 32'(bus.oResvOk), 32'd0);
    check("t4_va", 32'(bus.oValidA), 32'd0);
    check("t4_vb", 32'(bus.oValidB), 32'd1);
    for (int k = 1; k < 15; k++) begin
      if (k == 14) bus.iClear = 1'b1;
      tick();
      check($sformatf("t4_busy%0d", k),
            32'(bus.oBusy), 32'd1);
    end
    idle_in();
    tick();
    #1;
    check("t4_done", 32'(bus.oBusy), 32'd0);
    for (int a = 0; a < 16; a++) begin
      bus.iAddrA = 4'(a);
      bus.iAddrB = 4'(a);
      #1;
      check($sformatf("t4_r%0d", a),
            bus.oRegA, 32'd0);
      check($sformatf("t4_v%0d", a),
            32'(bus.oValidA), 32'd1);
    end
    tick();
    #1;
    check("t4_noretrig", 32'(bus.oBusy), 32'd0);

    // 5: reset mid-sweep at counter 6
    wr(4'd12, 32'hCC);
    bus.iReserve = 1'b1;
    bus.iAddrR   = 4'd13;
    tick();
    bus.iReserve = 1'b0;
    bus.iClear   = 1'b1;
    tick();
    bus.iClear = 1'b0;
    repeat (5) tick();
    bus.iAddrA = 4'd12;
    bus.iAddrB = 4'd13;
    #1;
    check("t5_busy", 32'(bus.oBusy), 32'd1);
    check("t5_keep", bus.oRegA, 32'hCC);
    nRst = 1'b0;
    #1;
    check("t5_rbusy", 32'(bus.oBusy), 32'd0);
    check("t5_r12", bus.oRegA, 32'd0);
    check("t5_vb", 32'(bus.oValidB), 32'd1);
    #2;
    nRst = 1'b1;
    tick();
    check("t5_idle", 32'(bus.oBusy), 32'd0);
    wr(4'd12, 32'h77);
    #1;
    check("t5_wr", bus.oRegA, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
